// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state, ALU command, select and instruction-field definitions
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [4:0] CMD_ADD = 5'b00100;
  localparam logic [4:0] CMD_SUB = 5'b00010;

  localparam logic [1:0] SRC1_RN = 2'b00;
  localparam logic [1:0] SRC1_RS = 2'b01;
  localparam logic [1:0] SRC1_PC = 2'b10;

  localparam logic [2:0] SH_IMM       = 3'b000;
  localparam logic [2:0] SH_IMM_SHIFT = 3'b001;
  localparam logic [2:0] SH_REG_SHIFT = 3'b010;
  localparam logic [2:0] SH_BRANCH    = 3'b100;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_LS  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_UND = 2'b11;

  localparam logic [3:0] COND_NV = 4'b1111;
  localparam logic [3:0] REG_PC  = 4'b1111;

  localparam int COND_HI   = 31;
  localparam int COND_LO   = 28;
  localparam int CLS_HI    = 27;
  localparam int CLS_LO    = 26;
  localparam int IMM_BIT   = 25;
  localparam int OPC_HI    = 24;
  localparam int OPC_LO    = 21;
  localparam int UP_BIT    = 23;
  localparam int S_BIT     = 20;
  localparam int LOAD_BIT  = 20;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 12;
  localparam int SHREG_BIT = 4;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluation against NZCV flags
module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  // 1110 (AL) and the 1111 encoding both report pass; the caller handles 1111 itself.
  always_comb begin
    pass = 1'b1;
    unique case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer
module multicycle_controller
  import proc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             run,
  input  logic [31:0]      instruction,
  input  logic [3:0]       flags,
  input  logic             dmem_ready,
  output logic [31:0]      ir,
  output logic             pc_wen,
  output logic             wen_rd,
  output logic             wen_dmem,
  output logic             wen_flags,
  output logic [4:0]       cmd,
  output logic             select_x,
  output logic             select_y,
  output logic [1:0]       select_src1,
  output logic [2:0]       select_src2shift,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int MW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MW-1:0] MEM_LAST = MW'(MEM_TIMEOUT - 1);

  state_t           cur, nxt;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;
  logic             fault_q;
  logic [MW-1:0]    mem_cnt;
  logic             run_armed;
  logic             latch_ir;
  logic             retire;
  logic             cond_pass;

  logic [1:0] cls;
  logic [3:0] opc;
  logic       is_load;
  logic       is_cmp;
  logic       rd_is_pc;

  logic [4:0] op_cmd;
  logic [1:0] op_src1;
  logic [2:0] op_src2;

  assign cls      = ir_q[CLS_HI:CLS_LO];
  assign opc      = ir_q[OPC_HI:OPC_LO];
  assign is_load  = ir_q[LOAD_BIT];
  assign is_cmp   = (opc[3:2] == 2'b10);
  assign rd_is_pc = (ir_q[RD_HI:RD_LO] == REG_PC);

  cond_check u_cond_check (
    .cond (ir_q[COND_HI:COND_LO]),
    .nzcv (flags),
    .pass (cond_pass)
  );

  // Operand routing per class; held from EXECUTE through MEM/WRITEBACK so results stay stable.
  always_comb begin
    op_cmd  = 5'b00000;
    op_src1 = SRC1_RN;
    op_src2 = SH_IMM;
    unique case (cls)
      CLS_DP: begin
        op_cmd = {1'b0, opc};
        if (ir_q[IMM_BIT])        op_src2 = SH_IMM;
        else if (!ir_q[SHREG_BIT]) op_src2 = SH_IMM_SHIFT;
        else                       op_src2 = SH_REG_SHIFT;
      end
      CLS_LS: op_cmd = ir_q[UP_BIT] ? CMD_ADD : CMD_SUB;
      CLS_BR: begin
        op_cmd  = CMD_ADD;
        op_src1 = SRC1_PC;
        op_src2 = SH_BRANCH;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt              = cur;
    pc_wen           = 1'b0;
    wen_rd           = 1'b0;
    wen_dmem         = 1'b0;
    wen_flags        = 1'b0;
    cmd              = 5'b00000;
    select_x         = 1'b0;
    select_y         = 1'b0;
    select_src1      = SRC1_RN;
    select_src2shift = SH_IMM;
    latch_ir         = 1'b0;
    retire           = 1'b0;
    unique case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        latch_ir = 1'b1;
        nxt      = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q[COND_HI:COND_LO] == COND_NV) begin
          nxt = S_HALT;
        end else if (!cond_pass) begin
          pc_wen = 1'b1;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        cmd              = op_cmd;
        select_src1      = op_src1;
        select_src2shift = op_src2;
        unique case (cls)
          CLS_DP: begin
            wen_flags = ir_q[S_BIT];
            nxt       = S_WRITEBACK;
          end
          CLS_LS: nxt = S_MEM;
          CLS_BR: begin
            // Branch target goes to R15 through the register file, not pc_wen.
            select_y = 1'b1;
            wen_rd   = 1'b1;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          default: begin
            pc_wen = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        cmd              = op_cmd;
        select_src1      = op_src1;
        select_src2shift = op_src2;
        wen_dmem         = ~is_load;
        if (dmem_ready) begin
          if (is_load) begin
            nxt = S_WRITEBACK;
          end else begin
            pc_wen = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        end else if (mem_cnt == MEM_LAST) begin
          nxt = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        cmd              = op_cmd;
        select_src1      = op_src1;
        select_src2shift = op_src2;
        wen_rd           = (cls == CLS_LS) | ~is_cmp;
        select_x         = (cls == CLS_LS);
        pc_wen           = ~rd_is_pc;
        retire           = 1'b1;
        nxt              = S_FETCH;
      end
      S_HALT: if (run && run_armed) nxt = S_FETCH;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cur       <= S_IDLE;
      ir_q      <= 32'h0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      mem_cnt   <= '0;
      run_armed <= 1'b0;
    end else begin
      cur <= nxt;
      if (latch_ir) ir_q <= instruction;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (nxt == S_FAULT) fault_q <= 1'b1;
      mem_cnt <= (cur == S_MEM) ? mem_cnt + MW'(1) : '0;
      // HALT exits only on a fresh run edge: run must be seen low while halted.
      if (cur != S_HALT) run_armed <= 1'b0;
      else if (!run)     run_armed <= 1'b1;
    end
  end

  assign ir      = ir_q;
  assign state   = cur;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        run;
  logic [31:0] instruction;
  logic [3:0]  flags;
  logic        dmem_ready;
  logic [31:0] ir;
  logic        pc_wen, wen_rd, wen_dmem, wen_flags;
  logic [4:0]  cmd;
  logic        select_x, select_y;
  logic [1:0]  select_src1;
  logic [2:0]  select_src2shift;
  logic [2:0]  state;
  logic        fault;
  logic [15:0] retired;

  multicycle_controller dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .run(run), .instruction(instruction),
    .flags(flags), .dmem_ready(dmem_ready), .ir(ir), .pc_wen(pc_wen), .wen_rd(wen_rd),
    .wen_dmem(wen_dmem), .wen_flags(wen_flags), .cmd(cmd), .select_x(select_x),
    .select_y(select_y), .select_src1(select_src1), .select_src2shift(select_src2shift),
    .state(state), .fault(fault), .retired(retired)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_retired = 0;

  int e_states[$];
  int e_end, e_pc, e_rd, e_dm, e_fl, e_ret, e_has_ex;
  int e_cmd, e_src1, e_src2, e_selx, e_sely, e_pc_st, e_rd_st;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Expected per-instruction behaviour, derived from the instruction's class and the latency rules.
  function automatic void model(input logic [31:0] ins, input logic [3:0] fl, input int delay);
    logic [3:0] opc;
    bit ld, rd15;
    opc  = ins[24:21];
    ld   = ins[20];
    rd15 = (ins[15:12] == 4'hF);
    e_states.delete();
    e_states.push_back(1);
    e_states.push_back(2);
    e_end = 1; e_pc = 0; e_rd = 0; e_dm = 0; e_fl = 0; e_ret = 1; e_has_ex = 0;
    e_cmd = 0; e_src1 = 0; e_src2 = 0; e_selx = 0; e_sely = 0; e_pc_st = 0; e_rd_st = 0;
    if (ins[31:28] == 4'hF) begin
      e_end = 6; e_ret = 0;
      return;
    end
    if (!cond_ok(ins[31:28], fl)) begin
      e_pc = 1; e_pc_st = 2;
      return;
    end
    e_has_ex = 1;
    e_states.push_back(3);
    case (ins[27:26])
      2'b00: begin
        e_cmd  = int'(opc);
        e_src2 = ins[25] ? 0 : (ins[4] ? 2 : 1);
        e_fl   = int'(ins[20]);
        e_states.push_back(5);
        e_rd    = (opc >= 8 && opc <= 11) ? 0 : 1;
        e_rd_st = e_rd ? 5 : 0;
        e_pc    = rd15 ? 0 : 1;
        e_pc_st = rd15 ? 0 : 5;
      end
      2'b01: begin
        e_cmd = ins[23] ? 4 : 2;
        if (delay >= 15) begin
          repeat (15) e_states.push_back(4);
          e_end = 7; e_ret = 0;
          e_dm  = ld ? 0 : 15;
        end else begin
          repeat (delay + 1) e_states.push_back(4);
          if (ld) begin
            e_states.push_back(5);
            e_rd = 1; e_rd_st = 5; e_selx = 1;
            e_pc = rd15 ? 0 : 1; e_pc_st = rd15 ? 0 : 5;
          end else begin
            e_dm = delay + 1; e_pc = 1; e_pc_st = 4;
          end
        end
      end
      2'b10: begin
        e_cmd = 4; e_src1 = 2; e_src2 = 4;
        e_rd = 1; e_rd_st = 3; e_sely = 1;
      end
      default: begin
        e_pc = 1; e_pc_st = 3;
      end
    endcase
  endfunction

  // Starts at a negedge with state == FETCH; returns at the negedge where the next phase begins.
  task automatic do_instr(input logic [31:0] ins, input logic [3:0] fl, input int delay);
    int st[$];
    int mem_k, guard, pcn, rdn, dmn, fln, pc_st, rd_st;
    int o_cmd, o_src1, o_src2, o_selx, o_sely;
    model(ins, fl, delay);
    instruction = ins;
    flags = fl;
    mem_k = 0; guard = 0; pcn = 0; rdn = 0; dmn = 0; fln = 0; pc_st = 0; rd_st = 0;
    o_cmd = 0; o_src1 = 0; o_src2 = 0; o_selx = 0; o_sely = 0;
    while (guard < 60) begin
      if (st.size() > 0 && (state == 3'd1 || state == 3'd6 || state == 3'd7)) break;
      dmem_ready = (state == 3'd4) && (mem_k == delay);
      #1;
      st.push_back(int'(state));
      if (pc_wen)    begin pcn++; pc_st = int'(state); end
      if (wen_rd)    begin rdn++; rd_st = int'(state); o_selx = int'(select_x); o_sely = int'(select_y); end
      if (wen_dmem)  dmn++;
      if (wen_flags) fln++;
      if (state == 3'd3) begin
        o_cmd = int'(cmd); o_src1 = int'(select_src1); o_src2 = int'(select_src2shift);
      end
      if (state == 3'd4) mem_k++;
      @(negedge CLOCK_50);
      guard++;
    end
    dmem_ready = 1'b0;
    exp_retired += e_ret;
    check_eq("seq_len", st.size(), e_states.size());
    for (int i = 0; i < st.size() && i < e_states.size(); i++)
      check_eq("seq_state", st[i], e_states[i]);
    check_eq("end_state", state, e_end);
    check_eq("ir", ir, ins);
    check_eq("pc_wen_cnt", pcn, e_pc);
    check_eq("wen_rd_cnt", rdn, e_rd);
    check_eq("wen_dmem_cnt", dmn, e_dm);
    check_eq("wen_flags_cnt", fln, e_fl);
    check_eq("pc_wen_state", pc_st, e_pc_st);
    check_eq("wen_rd_state", rd_st, e_rd_st);
    check_eq("retired", retired, exp_retired[15:0]);
    if (e_has_ex) begin
      check_eq("exec_cmd", o_cmd, e_cmd);
      check_eq("exec_src1", o_src1, e_src1);
      check_eq("exec_src2", o_src2, e_src2);
    end
    if (e_rd > 0) begin
      check_eq("sel_x", o_selx, e_selx);
      check_eq("sel_y", o_sely, e_sely);
    end
  endtask

  task automatic rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    ins[31:28] = 4'($urandom_range(0, 14));
    do_instr(ins, 4'($urandom), $urandom_range(0, 4));
  endtask

  task automatic wait_state(input int s, input string tag);
    int g;
    g = 0;
    while (state != 3'(s) && g < 40) begin
      @(negedge CLOCK_50);
      g++;
    end
    check_eq(tag, state, s);
  endtask

  initial begin
    RESET_N = 1'b0; run = 1'b0; instruction = 32'h0; flags = 4'h0; dmem_ready = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_state", state, 0);
    check_eq("rst_ir", ir, 0);
    check_eq("rst_retired", retired, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_enables", {pc_wen, wen_rd, wen_dmem, wen_flags}, 0);
    check_eq("rst_selects", {cmd, select_x, select_y, select_src1, select_src2shift}, 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check_eq("idle_hold", state, 0);
    run = 1'b1;
    @(negedge CLOCK_50);
    check_eq("idle_to_fetch", state, 1);

    do_instr(32'hE2821005, 4'h0, 0);
    do_instr(32'hE1520003, 4'h0, 0);
    do_instr(32'h0A000002, 4'b0100, 0);
    do_instr(32'h1A000002, 4'b0100, 0);
    do_instr(32'hE5921000, 4'h0, 3);
    do_instr(32'hE5821000, 4'h0, 0);
    for (int i = 0; i < 60; i++) rand_instr();

    do_instr(32'hF0000000, 4'h0, 0);
    repeat (4) @(negedge CLOCK_50);
    check_eq("halt_run_held", state, 6);
    check_eq("halt_enables", {pc_wen, wen_rd, wen_dmem, wen_flags}, 0);
    run = 1'b0;
    @(negedge CLOCK_50);
    check_eq("halt_run_low", state, 6);
    run = 1'b1;
    @(negedge CLOCK_50);
    check_eq("halt_to_fetch", state, 1);
    for (int i = 0; i < 20; i++) rand_instr();

    do_instr(32'hE5821000, 4'h0, 100);
    check_eq("fault_flag", fault, 1);
    run = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    run = 1'b1; dmem_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    dmem_ready = 1'b0;
    check_eq("fault_sticky", state, 7);
    check_eq("fault_enables", {pc_wen, wen_rd, wen_dmem, wen_flags}, 0);

    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    check_eq("fault_clr", fault, 0);
    check_eq("fault_rst_state", state, 0);
    exp_retired = 0;
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    wait_state(1, "rerun_fetch");
    do_instr(32'hE2821005, 4'h0, 0);
    instruction = 32'hE5821000;
    wait_state(4, "mid_mem_enter");
    repeat (2) @(negedge CLOCK_50);
    #1;
    check_eq("mid_mem_wen_dmem", wen_dmem, 1);
    #1;
    RESET_N = 1'b0;
    #1;
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_wen_dmem", wen_dmem, 0);
    check_eq("async_rst_retired", retired, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
